// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: state encodings and requester ids shared by the arbiter files
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    localparam logic ARB_REQ_I = 1'b0;
    localparam logic ARB_REQ_D = 1'b1;

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cache request/response and memory bus bundle around the arbiter
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WIDTH = 128
);

    logic                  i_enable, i_op, i_op_done, i_grant, i_data_ready, i_memory_in_use;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_data_in, i_data_out;
    logic                  d_enable, d_op, d_op_done, d_grant, d_data_ready, d_memory_in_use;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_data_in, d_data_out;
    logic                  mem_enable, mem_op_init, mem_op, mem_op_done, mem_data_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_data_in, mem_data_out;
    logic                  timeout_error;

    modport slave (
        input  i_enable, i_op, i_address, i_data_in, i_op_done,
        output i_grant, i_data_ready, i_data_out, i_memory_in_use,
        input  d_enable, d_op, d_address, d_data_in, d_op_done,
        output d_grant, d_data_ready, d_data_out, d_memory_in_use,
        output mem_enable, mem_op_init, mem_op, mem_address, mem_data_in, mem_op_done,
        input  mem_data_ready, mem_data_out,
        output timeout_error
    );

    modport master (
        output i_enable, i_op, i_address, i_data_in, i_op_done,
        input  i_grant, i_data_ready, i_data_out, i_memory_in_use,
        output d_enable, d_op, d_address, d_data_in, d_op_done,
        input  d_grant, d_data_ready, d_data_out, d_memory_in_use,
        input  mem_enable, mem_op_init, mem_op, mem_address, mem_data_in, mem_op_done,
        output mem_data_ready, mem_data_out,
        input  timeout_error
    );

endinterface

// File: rtl/memory_arbiter_rr_picker2.sv
// memory_arbiter_rr_picker2: two-way round-robin pick, the requester not served last wins a tie
module memory_arbiter_rr_picker2
    import memory_arbiter_pkg::*;
(
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic pick_o
);

    assign valid_o = i_req_i | d_req_i;
    assign pick_o  = (i_req_i & d_req_i) ? ~last_grant_i : (d_req_i ? ARB_REQ_D : ARB_REQ_I);

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one memory between the I and D caches with hang timeout
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 256
)(
    input logic                clk,
    input logic                reset,
    memory_arbiter_if.slave    bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;
    logic          gi, gd, g, odone, tout, pv, pick;

    memory_arbiter_rr_picker2 u_pick (
        .i_req_i      (bus.i_enable),
        .d_req_i      (bus.d_enable),
        .last_grant_i (last_q),
        .valid_o      (pv),
        .pick_o       (pick)
    );

    assign gi    = state_q == ARB_GNT_I;
    assign gd    = state_q == ARB_GNT_D;
    assign g     = gi | gd;
    assign odone = gi ? bus.i_op_done : (gd & bus.d_op_done);
    assign tout  = g & (cnt_q == CW'(TIMEOUT_CYCLES - 1)) & ~odone;

    // grant from IDLE, release on op_done or timeout, count granted cycles
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = g ? cnt_q + CW'(1) : '0;
        terr_d  = terr_q | tout;
        if (!g && pv) begin
            state_d = pick ? ARB_GNT_D : ARB_GNT_I;
            last_d  = pick;
        end else if (odone | tout) begin
            state_d = ARB_IDLE;
        end
    end

    // state, last grantee, cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            last_q  <= ARB_REQ_I;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.mem_enable      = gi ? bus.i_enable  : (gd & bus.d_enable);
    assign bus.mem_op          = gi ? bus.i_op      : (gd & bus.d_op);
    assign bus.mem_address     = gi ? bus.i_address : (gd ? bus.d_address : {ADDR_WIDTH{1'b0}});
    assign bus.mem_data_in     = gi ? bus.i_data_in : (gd ? bus.d_data_in : {LINE_WIDTH{1'b0}});
    assign bus.mem_op_init     = g & (cnt_q == '0);
    assign bus.mem_op_done     = odone | tout;
    assign bus.i_grant         = gi;
    assign bus.d_grant         = gd;
    assign bus.i_memory_in_use = gd;
    assign bus.d_memory_in_use = gi;
    assign bus.i_data_ready    = gi & bus.mem_data_ready & ~tout;
    assign bus.d_data_ready    = gd & bus.mem_data_ready & ~tout;
    assign bus.i_data_out      = gi ? bus.mem_data_out : {LINE_WIDTH{1'b0}};
    assign bus.d_data_out      = gd ? bus.mem_data_out : {LINE_WIDTH{1'b0}};
    assign bus.timeout_error   = terr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed cache traffic against a fake memory, checked by an ownership model
module tb_memory_arbiter;

    localparam int AW = 12;
    localparam int LW = 128;
    localparam int TO = 16;
    localparam logic [LW-1:0] L1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [LW-1:0] L2 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    localparam logic [LW-1:0] A5 = {16{8'hA5}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    memory_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();

    memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // fake memory: starts on op_init, raises data_ready after a fixed latency, holds it until op_done
    logic [LW-1:0] mem [0:4095];
    logic          s_rst, s_init, s_done, s_op;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_din;
    bit            m_busy;
    int            m_cnt;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h010] = L1;
        mem[12'h020] = L2;
    end

    always begin
        @(negedge clk);
        s_rst = reset; s_init = bus.mem_op_init; s_done = bus.mem_op_done;
        s_op = bus.mem_op; s_addr = bus.mem_address; s_din = bus.mem_data_in;
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_busy = 0; bus.mem_data_ready = 1'b0; bus.mem_data_out = '0;
        end else if (s_done) begin
            m_busy = 0; bus.mem_data_ready = 1'b0;
        end else if (s_init) begin
            m_busy = 1; m_cnt = 4;
        end else if (m_busy && !bus.mem_data_ready) begin
            m_cnt--;
            if (m_cnt == 0) begin
                if (!s_op) mem[s_addr] = s_din;
                bus.mem_data_out = s_op ? mem[s_addr] : '0;
                bus.mem_data_ready = 1'b1;
            end
        end
    end

    // ownership model: who holds memory, for how many cycles, who was served last
    int owner = -1;
    int age = 0;
    bit last = 0;
    bit err = 0;
    bit mvalid = 0;

    always @(negedge clk) begin
        logic          en [2];
        logic          op [2];
        logic          dn [2];
        logic [AW-1:0] ad [2];
        logic [LW-1:0] di [2];
        logic [10:0]   ev, av;
        bit            g, to, rdy;
        int            oi;
        en[0] = bus.i_enable; op[0] = bus.i_op; dn[0] = bus.i_op_done; ad[0] = bus.i_address; di[0] = bus.i_data_in;
        en[1] = bus.d_enable; op[1] = bus.d_op; dn[1] = bus.d_op_done; ad[1] = bus.d_address; di[1] = bus.d_data_in;
        g   = owner >= 0;
        oi  = g ? owner : 0;
        rdy = bus.mem_data_ready;
        to  = g && age == TO - 1 && !dn[oi];
        if (mvalid) begin
            ev = {owner == 0, owner == 0 && rdy && !to, owner == 1,
                  owner == 1, owner == 1 && rdy && !to, owner == 0,
                  g && en[oi], g && age == 0, g && op[oi], g && (dn[oi] || to), err};
            av = {bus.i_grant, bus.i_data_ready, bus.i_memory_in_use,
                  bus.d_grant, bus.d_data_ready, bus.d_memory_in_use,
                  bus.mem_enable, bus.mem_op_init, bus.mem_op, bus.mem_op_done, bus.timeout_error};
            chk("model_ctl", 128'(av), 128'(ev));
            chk("model_mem_address", 128'(bus.mem_address), 128'(g ? ad[oi] : '0));
            chk("model_mem_data_in", bus.mem_data_in, g ? di[oi] : '0);
            chk("model_i_data_out", bus.i_data_out, owner == 0 ? bus.mem_data_out : '0);
            chk("model_d_data_out", bus.d_data_out, owner == 1 ? bus.mem_data_out : '0);
        end
        if (reset) begin
            owner = -1; age = 0; last = 0; err = 0; mvalid = 1;
        end else if (mvalid) begin
            if (!g) begin
                if (en[0] && en[1]) owner = last ? 0 : 1;
                else if (en[0]) owner = 0;
                else if (en[1]) owner = 1;
                if (owner >= 0) begin last = owner[0]; age = 0; end
            end else if (dn[oi] || to) begin
                err = err | to;
                owner = -1;
            end else begin
                age++;
            end
        end
    end

    function automatic logic grant(input int s);
        return s != 0 ? bus.d_grant : bus.i_grant;
    endfunction

    function automatic logic ready(input int s);
        return s != 0 ? bus.d_data_ready : bus.i_data_ready;
    endfunction

    function automatic logic [LW-1:0] dout(input int s);
        return s != 0 ? bus.d_data_out : bus.i_data_out;
    endfunction

    task automatic set_req(input int s, input logic en, input logic op, input logic [AW-1:0] a, input logic [LW-1:0] d);
        if (s != 0) begin bus.d_enable = en; bus.d_op = op; bus.d_address = a; bus.d_data_in = d; end
        else begin bus.i_enable = en; bus.i_op = op; bus.i_address = a; bus.i_data_in = d; end
    endtask

    task automatic set_done(input int s, input logic v);
        if (s != 0) bus.d_op_done = v;
        else bus.i_op_done = v;
    endtask

    // one cache transfer: request, wait grant, wait data, pulse op_done, drop request
    task automatic xfer(input int s, input logic op, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                        output logic [LW-1:0] rd, output int gc, output int dc);
        int n = 0;
        rd = '0; gc = -1; dc = -1;
        set_req(s, 1'b1, op, a, wd);
        do begin @(posedge clk); #2; n++; end while (!grant(s) && n < 200);
        chk($sformatf("grant_wait_%0d", s), 128'(grant(s)), 128'(1));
        if (!grant(s)) begin set_req(s, 1'b0, 1'b0, '0, '0); return; end
        gc = cyc; n = 0;
        while (!ready(s) && n < 50) begin @(posedge clk); #2; n++; end
        chk($sformatf("ready_wait_%0d", s), 128'(ready(s)), 128'(1));
        rd = dout(s); dc = cyc;
        set_done(s, 1'b1);
        @(posedge clk); #2;
        set_done(s, 1'b0);
        set_req(s, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_grant(input int s);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (!grant(s) && n < 20);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] rd, rd2;
        int gc, dc, gc2, dc2, c0;
        set_req(0, 1'b0, 1'b0, '0, '0); set_req(1, 1'b0, 1'b0, '0, '0);
        bus.i_op_done = 1'b0; bus.d_op_done = 1'b0;
        bus.mem_data_ready = 1'b0; bus.mem_data_out = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_i_grant", 128'(bus.i_grant), 128'(0));
        chk("rst_mem_enable", 128'(bus.mem_enable), 128'(0));
        chk("rst_timeout_error", 128'(bus.timeout_error), 128'(0));

        c0 = cyc;
        xfer(0, 1'b1, 12'h010, '0, rd, gc, dc);
        chk("t1_grant_latency", 128'(gc - c0), 128'(1));
        chk("t1_ready_latency", 128'(dc - gc), 128'(5));
        chk("t1_read_data", rd, L1);

        c0 = cyc;
        fork
            xfer(0, 1'b1, 12'h010, '0, rd, gc, dc);
            xfer(1, 1'b1, 12'h020, '0, rd2, gc2, dc2);
        join
        chk("t2_d_wins_tie", 128'(gc2 - c0), 128'(1));
        chk("t2_i_after_idle", 128'(gc - dc2), 128'(2));
        chk("t2_i_data", rd, L1);
        chk("t2_d_data", rd2, L2);
        c0 = cyc;
        fork
            xfer(0, 1'b1, 12'h020, '0, rd, gc, dc);
            xfer(1, 1'b1, 12'h010, '0, rd2, gc2, dc2);
        join
        chk("t2_tie2_d_first", 128'(gc2 - c0), 128'(1));
        chk("t2_tie2_i_second", 128'(gc - dc2), 128'(2));
        chk("t2_tie2_i_data", rd, L2);

        xfer(1, 1'b0, 12'hFFF, A5, rd2, gc2, dc2);
        xfer(0, 1'b1, 12'hFFF, '0, rd, gc, dc);
        chk("t3_readback", rd, A5);

        set_req(0, 1'b1, 1'b1, 12'h030, '0);
        wait_grant(0);
        chk("t4_grant", 128'(bus.i_grant), 128'(1));
        for (int k = 1; k <= TO; k++) begin
            if (k == TO - 1) begin
                chk("t4_pre_op_done", 128'(bus.mem_op_done), 128'(0));
                chk("t4_pre_ready", 128'(bus.i_data_ready), 128'(1));
            end
            if (k == TO) begin
                chk("t4_forced_op_done", 128'(bus.mem_op_done), 128'(1));
                chk("t4_ready_gated", 128'(bus.i_data_ready), 128'(0));
            end
            if (k < TO) begin @(posedge clk); #2; end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;
        chk("t4_released", 128'(bus.i_grant), 128'(0));
        chk("t4_error_set", 128'(bus.timeout_error), 128'(1));
        xfer(1, 1'b1, 12'h010, '0, rd2, gc2, dc2);
        chk("t4_after_data", rd2, L1);
        chk("t4_error_sticky", 128'(bus.timeout_error), 128'(1));

        set_req(0, 1'b1, 1'b1, 12'h020, '0);
        wait_grant(0);
        repeat (2) begin @(posedge clk); #2; end
        chk("t5_third_cycle_granted", 128'(bus.i_grant), 128'(1));
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;
        chk("t5_i_grant", 128'(bus.i_grant), 128'(0));
        chk("t5_mem_enable", 128'(bus.mem_enable), 128'(0));
        chk("t5_mem_address", 128'(bus.mem_address), 128'(0));
        chk("t5_d_in_use", 128'(bus.d_memory_in_use), 128'(0));
        chk("t5_error_cleared", 128'(bus.timeout_error), 128'(0));
        reset = 1'b0;
        c0 = cyc;
        xfer(0, 1'b1, 12'h020, '0, rd, gc, dc);
        chk("t5_regrant_latency", 128'(gc - c0), 128'(1));
        chk("t5_regrant_data", rd, L2);

        fork
            xfer(0, 1'b1, 12'h010, '0, rd, gc, dc);
            begin
                wait_grant(0);
                @(posedge clk); #2;
                bus.d_op_done = 1'b1;
                #1;
                chk("t6_mem_op_done_low", 128'(bus.mem_op_done), 128'(0));
                @(posedge clk); #2;
                bus.d_op_done = 1'b0;
                chk("t6_i_still_granted", 128'(bus.i_grant), 128'(1));
            end
        join
        chk("t6_i_data", rd, L1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
